// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 32-bit words, buffers them and loads instruction memory.
// Optional legality checking is compiled in with `define ENCODER_CHECK_EN.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int IMEM_AW    = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_type,
  input  logic [2:0]         req_op,
  input  logic [1:0]         req_is,
  input  logic [4:0]         req_rd,
  input  logic [4:0]         req_ra,
  input  logic [4:0]         req_rb,
  input  logic [14:0]        req_imm,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IMEM_AW:0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [IMEM_AW-1:0] L_BASE  = IMEM_AW'(BASE_ADDR);
  localparam logic [PW:0]        L_DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wrPtr, r_rdPtr;
  logic [PW:0]        r_fifoCnt;
  logic [IMEM_AW-1:0] r_addr;
  logic               r_ovf;
  logic               r_imemWe;
  logic [IMEM_AW-1:0] r_imemAddr;
  logic [31:0]        r_imemWdata;
  logic               r_err;
  logic [IMEM_AW:0]   r_count;

  logic [31:0] w_word;
  logic        w_illegal, w_busy, w_empty, w_full, w_start;
  logic        w_accept, w_push, w_pop, w_ovfPop, w_wrPop;

  // Canonical packing: fields a given type does not use are forced to zero.
  always_comb begin
    w_word = '0;
    case (req_type)
      2'b01:   w_word = {req_type, req_op, req_is, req_rd, req_ra,
                         req_is[1] ? req_imm : {10'b0, req_rb}};
      2'b10:   w_word = {req_type, req_op[2], 4'b0000, req_rd, req_ra, 10'b0, req_rb};
      2'b11:   w_word = {req_type, req_op[2:1], 3'b000, req_rd, req_ra, 10'b0, req_rb};
      default: w_word = '0;
    endcase
  end

`ifdef ENCODER_CHECK_EN
  assign w_illegal = ((req_type == 2'b10) && (req_is != 2'b00)) ||
                     ((req_type == 2'b01) && (req_op >= 3'b101)) ||
                     ((req_type == 2'b11) && req_op[2]);
`else
  assign w_illegal = 1'b0;
`endif

  assign w_busy    = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_empty   = (r_fifoCnt == '0);
  assign w_full    = (r_fifoCnt == L_DEPTH);
  assign w_start   = start && (r_state == S_IDLE);
  assign req_ready = (r_state == S_LOAD) && !w_full;
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = w_busy && !w_empty;
  // A pop after the last address was written is the overflow event: no write, flush instead.
  assign w_ovfPop  = w_pop && r_ovf;
  assign w_wrPop   = w_pop && !r_ovf;
  assign w_push    = w_accept && !w_illegal && !w_ovfPop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_ovfPop) w_next = S_DONE;
        else if (w_accept && (req_type == 2'b00)) w_next = S_DRAIN;
      end
      S_DRAIN: if (w_ovfPop || w_empty) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fifoCnt   <= '0;
      r_addr      <= L_BASE;
      r_ovf       <= 1'b0;
      r_imemWe    <= 1'b0;
      r_imemAddr  <= L_BASE;
      r_imemWdata <= '0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_imemWe <= w_wrPop;
      if (w_wrPop) begin
        r_imemAddr  <= r_addr;
        r_imemWdata <= r_mem[r_rdPtr];
        r_count     <= r_count + (IMEM_AW+1)'(1);
        if (r_addr == '1) r_ovf  <= 1'b1;
        else              r_addr <= r_addr + IMEM_AW'(1);
      end
      if (w_start) begin
        r_addr  <= L_BASE;
        r_ovf   <= 1'b0;
        r_err   <= 1'b0;
        r_count <= '0;
      end
      if (w_ovfPop) begin
        r_err     <= 1'b1;
        r_wrPtr   <= '0;
        r_rdPtr   <= '0;
        r_fifoCnt <= '0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
        if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_fifoCnt <= r_fifoCnt + (PW+1)'(1);
          2'b01:   r_fifoCnt <= r_fifoCnt - (PW+1)'(1);
          default: r_fifoCnt <= r_fifoCnt;
        endcase
      end
      if (w_accept && w_illegal) r_err <= 1'b1;
    end
  end

  assign imem_we    = r_imemWe;
  assign imem_addr  = r_imemAddr;
  assign imem_wdata = r_imemWdata;
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default instance and a tiny-memory instance for the overflow case.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        startA, startB, validA, validB;
  logic [1:0]  reqType;
  logic [2:0]  reqOp;
  logic [1:0]  reqIs;
  logic [4:0]  reqRd, reqRa, reqRb;
  logic [14:0] reqImm;

  logic        readyA, weA, busyA, doneA, errA;
  logic [7:0]  addrA;
  logic [31:0] dataA;
  logic [8:0]  countA;

  logic        readyB, weB, busyB, doneB, errB;
  logic [1:0]  addrB;
  logic [31:0] dataB;
  logic [2:0]  countB;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wrA[$];
  wr_t wrB[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  weOutside = 0;
  int  doneCntA = 0;
  int  doneCntB = 0;
  int  lastAcceptCyc = 0;
  int  doneCyc = 0;

  instr_encoder #(.FIFO_DEPTH(4), .IMEM_AW(8), .BASE_ADDR(0)) dutA (
    .clk(clk), .rst(rst), .start(startA), .req_valid(validA), .req_ready(readyA),
    .req_type(reqType), .req_op(reqOp), .req_is(reqIs), .req_rd(reqRd), .req_ra(reqRa),
    .req_rb(reqRb), .req_imm(reqImm), .imem_we(weA), .imem_addr(addrA), .imem_wdata(dataA),
    .busy(busyA), .done(doneA), .err(errA), .count(countA)
  );

  instr_encoder #(.FIFO_DEPTH(4), .IMEM_AW(2), .BASE_ADDR(2)) dutB (
    .clk(clk), .rst(rst), .start(startB), .req_valid(validB), .req_ready(readyB),
    .req_type(reqType), .req_op(reqOp), .req_is(reqIs), .req_rd(reqRd), .req_ra(reqRa),
    .req_rb(reqRb), .req_imm(reqImm), .imem_we(weB), .imem_addr(addrB), .imem_wdata(dataB),
    .busy(busyB), .done(doneB), .err(errB), .count(countB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor: logs every write with the cycle it was seen in.
  always @(negedge clk) begin
    wr_t w;
    if (weA) begin
      w.addr = int'(addrA); w.data = dataA; w.cyc = cyc;
      wrA.push_back(w);
      if (!busyA) weOutside++;
    end
    if (weB) begin
      w.addr = int'(addrB); w.data = dataB; w.cyc = cyc;
      wrB.push_back(w);
      if (!busyB) weOutside++;
    end
    if (doneA) doneCntA++;
    if (doneB) doneCntB++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic wr_t wrAt(input bit sel, input int i);
    wr_t r;
    r.addr = -1; r.data = 'x; r.cyc = -1;
    if (sel) begin
      if (i < wrB.size()) r = wrB[i];
    end else if (i < wrA.size()) begin
      r = wrA[i];
    end
    return r;
  endfunction

  task automatic pulseStart(input bit sel);
    if (sel) startB = 1'b1; else startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic applyStimulus(input bit sel, input logic [1:0] t, input logic [2:0] op,
                               input logic [1:0] is, input logic [4:0] rd, input logic [4:0] ra,
                               input logic [4:0] rb, input logic [14:0] imm);
    int n = 0;
    reqType = t; reqOp = op; reqIs = is; reqRd = rd; reqRa = ra; reqRb = rb; reqImm = imm;
    if (sel) validB = 1'b1; else validA = 1'b1;
    while (!(sel ? readyB : readyA) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqAccepted", sel ? readyB : readyA, 1);
    @(negedge clk);
    lastAcceptCyc = cyc;
    validA = 1'b0;
    validB = 1'b0;
  endtask

  task automatic waitDone(input bit sel);
    int n = 0;
    while (!(sel ? doneB : doneA) && n < 100) begin
      @(negedge clk);
      n++;
    end
    doneCyc = cyc;
    checkOutput("doneSeen", sel ? doneB : doneA, 1);
    checkOutput("busyLowAtDone", sel ? busyB : busyA, 0);
    @(negedge clk);
    checkOutput("doneOneCycle", sel ? doneB : doneA, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    wr_t w;
    int  addAccept, termAccept, n;

    rst = 1'b1; startA = 0; startB = 0; validA = 0; validB = 0;
    reqType = 0; reqOp = 0; reqIs = 0; reqRd = 0; reqRa = 0; reqRb = 0; reqImm = 0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", readyA, 0);
    checkOutput("rstWe", weA, 0);
    checkOutput("rstAddr", addrA, 0);
    checkOutput("rstAddrB", addrB, 2);
    checkOutput("rstWdata", dataA, 0);
    checkOutput("rstBusyDoneErr", {busyA, doneA, errA}, 0);
    checkOutput("rstCount", countA, 0);
    rst = 1'b0;
    @(negedge clk);

    // ADD followed by a system terminator carrying junk fields
    $display("[TB] session 1: ADD + terminator");
    wrA.delete();
    pulseStart(0);
    applyStimulus(0, 2'b01, 3'b000, 2'b00, 5'd3, 5'd1, 5'd2, 15'd0);
    addAccept = lastAcceptCyc;
    applyStimulus(0, 2'b00, 3'b101, 2'b11, 5'd31, 5'd31, 5'd31, 15'h7fff);
    termAccept = lastAcceptCyc;
    waitDone(0);
    checkOutput("s1Writes", wrA.size(), 2);
    w = wrAt(0, 0);
    checkOutput("s1AddAddr", w.addr, 0);
    checkOutput("s1AddData", w.data, 32'h40308002);
    checkOutput("s1AddLatency", w.cyc, addAccept + 1);
    w = wrAt(0, 1);
    checkOutput("s1TermAddr", w.addr, 1);
    checkOutput("s1TermData", w.data, 32'h00000000);
    checkOutput("s1TermLatency", w.cyc, termAccept + 1);
    checkOutput("s1DoneCycle", doneCyc, termAccept + 2);
    checkOutput("s1Count", countA, 2);
    checkOutput("s1Err", errA, 0);

    $display("[TB] session 2: data-proc immediate");
    wrA.delete();
    pulseStart(0);
    applyStimulus(0, 2'b01, 3'b001, 2'b10, 5'd4, 5'd5, 5'd7, 15'h1234);
    applyStimulus(0, 2'b00, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 15'd0);
    waitDone(0);
    w = wrAt(0, 0);
    checkOutput("s2Id", w.data[31:25], 7'h26);
    checkOutput("s2Imm", w.data[14:0], 15'h1234);
    checkOutput("s2Word", w.data, 32'h4C429234);
    checkOutput("s2Addr", w.addr, 0);

    $display("[TB] session 3: control and STR canonicalisation");
    wrA.delete();
    pulseStart(0);
    applyStimulus(0, 2'b11, 3'b011, 2'b11, 5'd1, 5'd2, 5'd3, 15'h7fff);
    applyStimulus(0, 2'b10, 3'b100, 2'b11, 5'd7, 5'd8, 5'd9, 15'h7fff);
    applyStimulus(0, 2'b00, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 15'd0);
    waitDone(0);
    w = wrAt(0, 0);
    checkOutput("s3CtrlWord", w.data, 32'hD0110003);
`ifdef ENCODER_CHECK_EN
    checkOutput("s3Writes", wrA.size(), 2);
    w = wrAt(0, 1);
    checkOutput("s3TermAddr", w.addr, 1);
    checkOutput("s3TermData", w.data, 32'h0);
    checkOutput("s3Err", errA, 1);
    checkOutput("s3Count", countA, 2);
`else
    checkOutput("s3Writes", wrA.size(), 3);
    w = wrAt(0, 1);
    checkOutput("s3StrAddr", w.addr, 1);
    checkOutput("s3StrId", w.data[31:25], 7'h50);
    checkOutput("s3StrWord", w.data, 32'hA0740009);
    checkOutput("s3Err", errA, 0);
    checkOutput("s3Count", countA, 3);
`endif

    $display("[TB] session 4: six back-to-back requests");
    wrA.delete();
    pulseStart(0);
    checkOutput("s4ErrCleared", errA, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 2'b01, 3'b000, 2'b00, 5'(i), 5'(i + 1), 5'(i + 2), 15'd0);
    applyStimulus(0, 2'b00, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 15'd0);
    waitDone(0);
    checkOutput("s4Writes", wrA.size(), 7);
    for (int i = 0; i < 6; i++) begin
      wr_t f;
      f = wrAt(0, 0);
      w = wrAt(0, i);
      checkOutput($sformatf("s4Addr%0d", i), w.addr, i);
      checkOutput($sformatf("s4Data%0d", i), w.data,
                  32'h40000000 | (i << 20) | ((i + 1) << 15) | (i + 2));
      checkOutput($sformatf("s4Cycle%0d", i), w.cyc, f.cyc + i);
    end

    $display("[TB] session 5: address overflow on small memory");
    wrB.delete();
    pulseStart(1);
    applyStimulus(1, 2'b01, 3'b010, 2'b00, 5'd1, 5'd2, 5'd3, 15'd0);
    applyStimulus(1, 2'b01, 3'b010, 2'b00, 5'd4, 5'd5, 5'd6, 15'd0);
    applyStimulus(1, 2'b01, 3'b010, 2'b00, 5'd7, 5'd8, 5'd9, 15'd0);
    applyStimulus(1, 2'b00, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 15'd0);
    waitDone(1);
    checkOutput("s5Writes", wrB.size(), 2);
    w = wrAt(1, 0);
    checkOutput("s5Addr0", w.addr, 2);
    checkOutput("s5Data0", w.data, 32'h50110003);
    w = wrAt(1, 1);
    checkOutput("s5Addr1", w.addr, 3);
    checkOutput("s5Err", errB, 1);
    checkOutput("s5Count", countB, 2);

    $display("[TB] session 6: reset mid-session");
    wrA.delete();
    pulseStart(0);
    applyStimulus(0, 2'b01, 3'b000, 2'b00, 5'd1, 5'd1, 5'd1, 15'd0);
    applyStimulus(0, 2'b01, 3'b000, 2'b00, 5'd2, 5'd2, 5'd2, 15'd0);
    applyStimulus(0, 2'b01, 3'b000, 2'b00, 5'd3, 5'd3, 5'd3, 15'd0);
    rst = 1'b1;
    #1;
    checkOutput("s6RstWe", weA, 0);
    checkOutput("s6RstAddr", addrA, 0);
    checkOutput("s6RstWdata", dataA, 0);
    checkOutput("s6RstReady", readyA, 0);
    checkOutput("s6RstBusyDoneErr", {busyA, doneA, errA}, 0);
    checkOutput("s6RstCount", countA, 0);
    @(negedge clk);
    rst = 1'b0;
    n = wrA.size();
    repeat (10) @(negedge clk);
    checkOutput("s6NoWriteAfterRst", wrA.size(), n);
    checkOutput("s6IdleAfterRst", busyA, 0);
    wrA.delete();
    pulseStart(0);
    applyStimulus(0, 2'b00, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 15'd0);
    waitDone(0);
    checkOutput("s6FreshWrites", wrA.size(), 1);
    w = wrAt(0, 0);
    checkOutput("s6FreshAddr", w.addr, 0);

    checkOutput("weOnlyWhenBusy", weOutside, 0);
    checkOutput("donePulsesA", doneCntA, 5);
    checkOutput("donePulsesB", doneCntB, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
